// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and overflow helper for multicycle_alu
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_NOT = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_NOR = 4'h6;
   localparam logic [3:0] OP_SLT = 4'h7;
   localparam logic [3:0] OP_SLL = 4'h8;
   localparam logic [3:0] OP_SRL = 4'h9;
   localparam logic [3:0] OP_SRA = 4'hA;
   localparam logic [3:0] OP_EQ  = 4'hB;
   localparam logic [3:0] OP_NE  = 4'hC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Signed overflow: operands (b inverted for sub) agree in sign but the result does not.
   function automatic logic addsub_ovf(input logic is_sub, input logic a_msb,
                                       input logic b_msb, input logic f_msb);
      logic signs_agree;
      signs_agree = is_sub ? (a_msb ^ b_msb) : ~(a_msb ^ b_msb);
      return signs_agree & (a_msb ^ f_msb);
   endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - operand/result handshake bundle for multicycle_alu
interface multicycle_alu_if #(
   parameter int WIDTH = 32
);
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [3:0]         op;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   f;
   logic               ovf;
   logic               zero;

   modport master (
      output in_valid, a, b, op, shamt, out_ready,
      input  in_ready, out_valid, f, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, op, shamt, out_ready,
      output in_ready, out_valid, f, ovf, zero
   );

endinterface

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - one-bit-per-cycle shifter, or a barrel shifter under ALU_BARREL_SHIFT_EN
// result_o is the value after this cycle's step; on start_i the first step is applied to data_i.
module alu_shift_unit #(
   parameter  int WIDTH   = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               dir_i,
   input  logic               arith_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [WIDTH-1:0]   data_i,
   output logic               busy_o,
   output logic               last_o,
   output logic [WIDTH-1:0]   result_o
);

`ifdef ALU_BARREL_SHIFT_EN

   logic unused_ok;
   assign unused_ok = ^{clk, rst, start_i};
   assign busy_o    = 1'b0;
   assign last_o    = 1'b0;

   always_comb begin
      result_o = data_i << shamt_i;
      if (dir_i) begin
         if (arith_i) result_o = $unsigned($signed(data_i) >>> shamt_i);
         else         result_o = data_i >> shamt_i;
      end
   end

`else

   logic [WIDTH-1:0]   data_q;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, arith_q;
   logic [WIDTH-1:0]   src;
   logic               dir_s, arith_s;

   always_comb begin
      src     = start_i ? data_i  : data_q;
      dir_s   = start_i ? dir_i   : dir_q;
      arith_s = start_i ? arith_i : arith_q;
      if (dir_s) result_o = {arith_s & src[WIDTH-1], src[WIDTH-1:1]};
      else       result_o = {src[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         if (shamt_i != '0) cnt_d = shamt_i - SHAMT_W'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - SHAMT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (start_i || cnt_q != '0) data_q <= result_o;
         if (start_i) begin
            dir_q   <= dir_i;
            arith_q <= arith_i;
         end
      end
   end

   assign busy_o = (cnt_q != '0);
   assign last_o = (cnt_q == SHAMT_W'(1));

`endif

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - registered ALU with valid/ready handshake; ALU_BARREL_SHIFT_EN selects one-cycle shifts
module multicycle_alu
   import alu_pkg::*;
#(
   parameter  int WIDTH   = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input logic             clk,
   input logic             rst,
   multicycle_alu_if.slave bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] f_q, f_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             accept;
   logic             is_shift;
   logic             shift_start;
   logic             shift_busy;
   logic             shift_last;
   logic [WIDTH-1:0] shift_result;
   logic [WIDTH-1:0] sum, diff;
   logic [WIDTH-1:0] alu_f;
   logic             alu_ovf, alu_zero;

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.f         = f_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

   assign accept   = bus.in_valid && bus.in_ready;
   assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
   assign sum      = bus.a + bus.b;
   assign diff     = bus.a - bus.b;

   alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .rst      (rst),
      .start_i  (shift_start),
      .dir_i    (bus.op != OP_SLL),
      .arith_i  (bus.op == OP_SRA),
      .shamt_i  (bus.shamt),
      .data_i   (bus.a),
      .busy_o   (shift_busy),
      .last_o   (shift_last),
      .result_o (shift_result)
   );

`ifdef ALU_BARREL_SHIFT_EN
   logic unused_shift;
   assign unused_shift = shift_busy ^ shift_last;
`else
   logic unused_shift;
   assign unused_shift = shift_busy;
`endif

   always_comb begin
      alu_f    = '0;
      alu_ovf  = 1'b0;
      alu_zero = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_f   = sum;
            alu_ovf = addsub_ovf(1'b0, bus.a[WIDTH-1], bus.b[WIDTH-1], sum[WIDTH-1]);
         end
         OP_SUB: begin
            alu_f   = diff;
            alu_ovf = addsub_ovf(1'b1, bus.a[WIDTH-1], bus.b[WIDTH-1], diff[WIDTH-1]);
         end
         OP_NOT: alu_f = ~bus.b;
         OP_AND: alu_f = bus.a & bus.b;
         OP_OR:  alu_f = bus.a | bus.b;
         OP_XOR: alu_f = bus.a ^ bus.b;
         OP_NOR: alu_f = ~(bus.a | bus.b);
         OP_SLT: alu_f = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         OP_SLL, OP_SRL, OP_SRA: alu_f = (bus.shamt == '0) ? bus.a : shift_result;
         OP_EQ:  alu_zero = (bus.a == bus.b);
         OP_NE:  alu_zero = (bus.a != bus.b);
         default: ;
      endcase
   end

   // The first shift step happens on the accept edge, so an n-bit shift reaches DONE n cycles later.
   always_comb begin
      state_d     = state_q;
      f_d         = f_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      shift_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               f_d         = alu_f;
               ovf_d       = alu_ovf;
               zero_d      = alu_zero;
               shift_start = is_shift;
               state_d     = DONE;
`ifndef ALU_BARREL_SHIFT_EN
               if (is_shift && bus.shamt > SHAMT_W'(1)) state_d = SHIFT;
`endif
            end
         end
`ifndef ALU_BARREL_SHIFT_EN
         SHIFT: begin
            f_d = shift_result;
            if (shift_last) state_d = DONE;
         end
`endif
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         f_q     <= '0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu at WIDTH=8 (honours ALU_BARREL_SHIFT_EN)
module tb_multicycle_alu;
   import alu_pkg::*;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] f;
      logic         ovf;
      logic         zero;
      int           id;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   seen = 1'b0;

   multicycle_alu_if #(.WIDTH(W)) bus ();

   multicycle_alu #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic int shift_lat(input int sh);
`ifdef ALU_BARREL_SHIFT_EN
      return 1;
`else
      return (sh == 0) ? 1 : sh;
`endif
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got f=%0h with no expected entry", bus.f);
            end else begin
               e = sb.pop_front();
               chk($sformatf("op%0d_f", e.id), bus.f, e.f);
               chk($sformatf("op%0d_ovf", e.id), bus.ovf, e.ovf);
               chk($sformatf("op%0d_zero", e.id), bus.zero, e.zero);
            end
         end else if (!bus.out_valid) begin
            seen = 1'b0;
         end
      end
   end

   task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] sh, input logic [W-1:0] ef,
                        input logic eovf, input logic ez, input int elat);
      int n;
      int lat;
      bit ir_bad;
      n = 0;
      ir_bad = 1'b0;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      bus.op = op; bus.a = a; bus.b = b; bus.shamt = sh;
      bus.in_valid = 1'b1;
      sb.push_back('{ef, eovf, ez, id});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = 8'($urandom); bus.b = 8'($urandom);
      bus.op = 4'($urandom); bus.shamt = 3'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 64) begin
         if (bus.in_ready) ir_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("op%0d_latency", id), lat, elat);
      if (elat > 1) chk($sformatf("op%0d_in_ready_low", id), ir_bad, 0);
      if (bus.out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit bp_bad;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.shamt = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("in_ready_in_reset", bus.in_ready, 0);
      rst = 1'b0;
      #1;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_f", bus.f, 0);
      chk("reset_ovf", bus.ovf, 0);
      chk("reset_zero", bus.zero, 0);
      chk("reset_in_ready", bus.in_ready, 1);

      issue(1,  OP_ADD, 8'h7F, 8'h01, 3'd0, 8'h80, 1'b1, 1'b0, 1);
      issue(2,  OP_SUB, 8'h80, 8'h01, 3'd0, 8'h7F, 1'b1, 1'b0, 1);
      issue(3,  OP_SLT, 8'hFF, 8'h01, 3'd0, 8'h01, 1'b0, 1'b0, 1);
      issue(4,  OP_SRA, 8'h90, 8'h00, 3'd3, 8'hF2, 1'b0, 1'b0, shift_lat(3));
      issue(5,  OP_EQ,  8'h5A, 8'h5A, 3'd0, 8'h00, 1'b0, 1'b1, 1);
      issue(6,  OP_NE,  8'h5A, 8'h5A, 3'd0, 8'h00, 1'b0, 1'b0, 1);
      issue(7,  4'hF,   8'hFF, 8'h01, 3'd5, 8'h00, 1'b0, 1'b0, 1);
      issue(8,  OP_NOT, 8'h00, 8'h0F, 3'd0, 8'hF0, 1'b0, 1'b0, 1);
      issue(9,  OP_AND, 8'hA5, 8'h3C, 3'd0, 8'h24, 1'b0, 1'b0, 1);
      issue(10, OP_OR,  8'hA5, 8'h3C, 3'd0, 8'hBD, 1'b0, 1'b0, 1);
      issue(11, OP_XOR, 8'hA5, 8'h3C, 3'd0, 8'h99, 1'b0, 1'b0, 1);
      issue(12, OP_NOR, 8'hA5, 8'h3C, 3'd0, 8'h42, 1'b0, 1'b0, 1);
      issue(13, OP_SLL, 8'h81, 8'h00, 3'd1, 8'h02, 1'b0, 1'b0, shift_lat(1));
      issue(14, OP_SRL, 8'h81, 8'h00, 3'd7, 8'h01, 1'b0, 1'b0, shift_lat(7));
      issue(15, OP_SLL, 8'h81, 8'h00, 3'd0, 8'h81, 1'b0, 1'b0, shift_lat(0));
      issue(16, OP_ADD, 8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b0, 1);
      issue(17, OP_SUB, 8'h7F, 8'hFF, 3'd0, 8'h80, 1'b1, 1'b0, 1);
      issue(18, OP_ADD, 8'h01, 8'h02, 3'd0, 8'h03, 1'b0, 1'b0, 1);
      issue(19, OP_SRA, 8'h40, 8'h00, 3'd2, 8'h10, 1'b0, 1'b0, shift_lat(2));

      // Backpressure: result must hold while the consumer stalls.
      bus.out_ready = 1'b0;
      issue(20, OP_ADD, 8'h12, 8'h34, 3'd0, 8'h46, 1'b0, 1'b0, 1);
      bp_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (!bus.out_valid || bus.f !== 8'h46 || bus.ovf !== 1'b0 ||
             bus.zero !== 1'b0 || bus.in_ready !== 1'b0) bp_bad = 1'b1;
      end
      chk("backpressure_hold", bp_bad, 0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_out_valid", bus.out_valid, 0);
      chk("bp_release_in_ready", bus.in_ready, 1);

      // Reset two cycles into a 7-bit shift.
      bus.op = OP_SLL; bus.a = 8'hFF; bus.b = 8'h00; bus.shamt = 3'd7;
      bus.in_valid = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
      sb.push_back('{8'h80, 1'b0, 1'b0, 21});
`endif
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_f", bus.f, 0);
      chk("abort_ovf", bus.ovf, 0);
      chk("abort_zero", bus.zero, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      repeat (8) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL abort_late_result: got out_valid=1, expected 0");
         end
      end
      issue(22, OP_ADD, 8'h05, 8'h03, 3'd0, 8'h08, 1'b0, 1'b0, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
